// File: rtl/led_matrix_pkg.sv
// Shared types and constants for the LED matrix frame buffer datapath.
package led_matrix_pkg;

   localparam int ADDRESS_WIDTH = 25;

   typedef struct packed {
      logic [2:0] red;
      logic [2:0] green;
      logic [1:0] blue;
   } rgb332_t;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_RD   = 2'd1,
      ARB_WR   = 2'd2
   } arb_state_t;

endpackage

// File: rtl/frame_flip_scheduler.sv
// Defers a host buffer-swap request to the next display frame boundary.
module frame_flip_scheduler
   import led_matrix_pkg::*;
(
   input  logic clk,
   input  logic reset_n,
   input  logic frame_start,
   input  logic flip_req,
   output logic frame_buffer_select,
   output logic flip_done
);

   logic flipPending_q;
   logic select_q;
   logic done_q;
   logic swap;

   // A request arriving on the boundary cycle itself is honoured immediately.
   assign swap = frame_start & (flipPending_q | flip_req);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         flipPending_q <= 1'b0;
         select_q      <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         done_q <= swap;
         if (swap) begin
            select_q      <= ~select_q;
            flipPending_q <= 1'b0;
         end else if (flip_req) begin
            flipPending_q <= 1'b1;
         end
      end
   end

   assign frame_buffer_select = select_q;
   assign flip_done           = done_q;

endmodule

// File: rtl/frame_ram_arbiter.sv
// Arbitrates display reads and host writes into a single registered RAM command slot.
module frame_ram_arbiter #(
   parameter int ADDRESS_WIDTH  = led_matrix_pkg::ADDRESS_WIDTH,
   parameter int RD_BURST_LIMIT = 8
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     rd_req,
   input  logic [ADDRESS_WIDTH-1:0] rd_address,
   output logic                     rd_grant,
   input  logic                     wr_req,
   input  logic [ADDRESS_WIDTH-1:0] wr_address,
   input  led_matrix_pkg::rgb332_t  wr_data,
   output logic                     wr_grant,
   output logic [ADDRESS_WIDTH-1:0] address_fifo,
   output logic                     wr_fifo,
   output led_matrix_pkg::rgb332_t  data_out_fifo,
   output logic                     data_out_ready_fifo,
   input  logic                     fifo_full,
   input  logic                     frame_start,
   input  logic                     flip_req,
   output logic                     frame_buffer_select,
   output logic                     flip_done
);
   import led_matrix_pkg::*;

   localparam int CNT_W = ($clog2(RD_BURST_LIMIT + 1) > 4) ? $clog2(RD_BURST_LIMIT + 1) : 4;

   arb_state_t               state_q;
   logic [ADDRESS_WIDTH-1:0] address_q;
   logic                     wr_q;
   rgb332_t                  data_q;
   logic                     ready_q;
   logic [CNT_W-1:0]         burstCnt_q;
   logic [CNT_W-1:0]         burstCnt_d;
   logic                     transfer;
   logic                     slotFree;
   logic                     burstFull;
   logic                     rdGrant;
   logic                     wrGrant;

   // Reads win unless a waiting write has already been starved for a full burst.
   always_comb begin
      transfer  = ready_q & ~fifo_full;
      slotFree  = ~ready_q | transfer;
      burstFull = wr_req & (burstCnt_q == CNT_W'(RD_BURST_LIMIT));
      rdGrant   = reset_n & slotFree & rd_req & ~burstFull;
      wrGrant   = reset_n & slotFree & wr_req & ~rdGrant;
   end

   always_comb begin
      burstCnt_d = burstCnt_q;
      if (!wr_req || wrGrant) begin
         burstCnt_d = '0;
      end else if (rdGrant) begin
         if (state_q != ARB_RD) begin
            burstCnt_d = CNT_W'(1);
         end else if (burstCnt_q != '1) begin
            burstCnt_d = burstCnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q    <= ARB_IDLE;
         address_q  <= '0;
         wr_q       <= 1'b0;
         data_q     <= '0;
         ready_q    <= 1'b0;
         burstCnt_q <= '0;
      end else begin
         burstCnt_q <= burstCnt_d;
         if (rdGrant) begin
            state_q   <= ARB_RD;
            address_q <= rd_address;
            wr_q      <= 1'b0;
            data_q    <= '0;
            ready_q   <= 1'b1;
         end else if (wrGrant) begin
            state_q   <= ARB_WR;
            address_q <= wr_address;
            wr_q      <= 1'b1;
            data_q    <= wr_data;
            ready_q   <= 1'b1;
         end else begin
            if (transfer) begin
               ready_q <= 1'b0;
            end
            if (slotFree && !rd_req && !wr_req) begin
               state_q <= ARB_IDLE;
            end
         end
      end
   end

   assign rd_grant            = rdGrant;
   assign wr_grant            = wrGrant;
   assign address_fifo        = address_q;
   assign wr_fifo             = wr_q;
   assign data_out_fifo       = data_q;
   assign data_out_ready_fifo = ready_q;

   frame_flip_scheduler u_flip (
      .clk                 (clk),
      .reset_n             (reset_n),
      .frame_start         (frame_start),
      .flip_req            (flip_req),
      .frame_buffer_select (frame_buffer_select),
      .flip_done           (flip_done)
   );

endmodule

// File: tb/tb_frame_ram_arbiter.sv
// Self-checking bench: vector table, directed corner sequences and randomized traffic vs. a reference model.
module tb_frame_ram_arbiter;

   localparam int AW    = 25;
   localparam int LIMIT = 8;

   logic          clk = 1'b0;
   logic          reset_n, rd_req, wr_req, fifo_full, frame_start, flip_req;
   logic [AW-1:0] rd_address, wr_address, address_fifo;
   logic [7:0]    wr_data, data_out_fifo;
   logic          rd_grant, wr_grant, wr_fifo, data_out_ready_fifo, frame_buffer_select, flip_done;

   always #5 clk = ~clk;

   frame_ram_arbiter #(.ADDRESS_WIDTH(AW), .RD_BURST_LIMIT(LIMIT)) dut (
      .clk                 (clk),
      .reset_n             (reset_n),
      .rd_req              (rd_req),
      .rd_address          (rd_address),
      .rd_grant            (rd_grant),
      .wr_req              (wr_req),
      .wr_address          (wr_address),
      .wr_data             (wr_data),
      .wr_grant            (wr_grant),
      .address_fifo        (address_fifo),
      .wr_fifo             (wr_fifo),
      .data_out_fifo       (data_out_fifo),
      .data_out_ready_fifo (data_out_ready_fifo),
      .fifo_full           (fifo_full),
      .frame_start         (frame_start),
      .flip_req            (flip_req),
      .frame_buffer_select (frame_buffer_select),
      .flip_done           (flip_done)
   );

   int checks = 0;
   int passes = 0;

   // Reference model: one pending command slot, a starvation tally and a flip latch.
   bit            mValid, mWr, mSel, mPend, mDone;
   logic [AW-1:0] mAddr;
   logic [7:0]    mData;
   int            mReads;

   typedef struct {
      logic rn, r, w, ff, fs, fr;
      logic [AW-1:0] ra, wa;
      logic [7:0] wd;
      logic [1:0] g;
      logic ready, wrf;
      logic [AW-1:0] addr;
      logic [7:0] data;
      logic sel, done;
   } vec_t;

   vec_t tbl[10];

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   function automatic logic [63:0] outVec();
      return {27'd0, data_out_ready_fifo, wr_fifo, address_fifo, data_out_fifo, frame_buffer_select, flip_done};
   endfunction

   function automatic logic [63:0] modelVec();
      return {27'd0, mValid, mWr, mAddr, mData, mSel, mDone};
   endfunction

   // Drives one cycle, checks grants before the edge and registers after it.
   task automatic applyStimulus(input logic rn, input logic r, input logic w, input logic ff,
                                input logic fs, input logic fr, input logic [AW-1:0] ra,
                                input logic [AW-1:0] wa, input logic [7:0] wd, output logic [1:0] g);
      logic [1:0] expG;
      bit free, swap;
      reset_n = rn; rd_req = r; wr_req = w; fifo_full = ff; frame_start = fs; flip_req = fr;
      rd_address = ra; wr_address = wa; wr_data = wd;
      #1;
      free = !mValid || !ff;
      expG = 2'b00;
      if (rn && free) begin
         if (r && !(w && mReads >= LIMIT)) expG = 2'b10;
         else if (w) expG = 2'b01;
      end
      g = {rd_grant, wr_grant};
      checkOutput("grants", 64'(g), 64'(expG));
      @(posedge clk);
      if (!rn) begin
         mValid = 0; mWr = 0; mAddr = '0; mData = '0; mSel = 0; mPend = 0; mDone = 0; mReads = 0;
      end else begin
         if (expG == 2'b10) begin
            mValid = 1; mWr = 0; mAddr = ra; mData = '0; mReads = w ? mReads + 1 : 0;
         end else if (expG == 2'b01) begin
            mValid = 1; mWr = 1; mAddr = wa; mData = wd; mReads = 0;
         end else begin
            if (mValid && !ff) mValid = 0;
            if (!w) mReads = 0;
         end
         swap  = fs && (mPend || fr);
         mDone = swap;
         if (swap) begin
            mSel = !mSel; mPend = 0;
         end else if (fr) begin
            mPend = 1;
         end
      end
      #1;
      checkOutput("outputs", outVec(), modelVec());
   endtask

   initial begin
      logic [1:0] g;
      logic rr, rw, rf, rs, rp, rn;
      mValid = 0; mWr = 0; mSel = 0; mPend = 0; mDone = 0; mAddr = '0; mData = '0; mReads = 0;

      tbl[0] = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 25'h10, 25'h0,   8'h00, 2'b10, 1'b1,1'b0, 25'h10,  8'h00, 1'b0,1'b0};
      tbl[1] = '{1'b1,1'b1,1'b1,1'b0,1'b0,1'b0, 25'h11, 25'h200, 8'hA5, 2'b10, 1'b1,1'b0, 25'h11,  8'h00, 1'b0,1'b0};
      tbl[2] = '{1'b1,1'b0,1'b1,1'b1,1'b0,1'b0, 25'h0,  25'h200, 8'hA5, 2'b00, 1'b1,1'b0, 25'h11,  8'h00, 1'b0,1'b0};
      tbl[3] = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b0, 25'h0,  25'h200, 8'hA5, 2'b01, 1'b1,1'b1, 25'h200, 8'hA5, 1'b0,1'b0};
      tbl[4] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b1, 25'h0,  25'h0,   8'h00, 2'b00, 1'b0,1'b1, 25'h200, 8'hA5, 1'b0,1'b0};
      tbl[5] = '{1'b1,1'b0,1'b0,1'b0,1'b1,1'b0, 25'h0,  25'h0,   8'h00, 2'b00, 1'b0,1'b1, 25'h200, 8'hA5, 1'b1,1'b1};
      tbl[6] = '{1'b1,1'b0,1'b0,1'b0,1'b1,1'b0, 25'h0,  25'h0,   8'h00, 2'b00, 1'b0,1'b1, 25'h200, 8'hA5, 1'b1,1'b0};
      tbl[7] = '{1'b1,1'b1,1'b0,1'b0,1'b1,1'b1, 25'h33, 25'h0,   8'h00, 2'b10, 1'b1,1'b0, 25'h33,  8'h00, 1'b0,1'b1};
      tbl[8] = '{1'b1,1'b0,1'b0,1'b0,1'b1,1'b0, 25'h0,  25'h0,   8'h00, 2'b00, 1'b0,1'b0, 25'h33,  8'h00, 1'b0,1'b0};
      tbl[9] = '{1'b0,1'b0,1'b1,1'b1,1'b0,1'b0, 25'h0,  25'h7,   8'h3C, 2'b00, 1'b0,1'b0, 25'h0,   8'h00, 1'b0,1'b0};

      applyStimulus(0, 0, 0, 0, 0, 0, '0, '0, '0, g);
      applyStimulus(0, 1, 1, 0, 0, 0, '0, '0, '0, g);
      checkOutput("reset state", outVec(), 64'd0);

      for (int i = 0; i < 10; i++) begin
         applyStimulus(tbl[i].rn, tbl[i].r, tbl[i].w, tbl[i].ff, tbl[i].fs, tbl[i].fr,
                       tbl[i].ra, tbl[i].wa, tbl[i].wd, g);
         checkOutput($sformatf("vec%0d grants", i), 64'(g), 64'(tbl[i].g));
         checkOutput($sformatf("vec%0d outputs", i), outVec(),
                     {27'd0, tbl[i].ready, tbl[i].wrf, tbl[i].addr, tbl[i].data, tbl[i].sel, tbl[i].done});
      end

      // Ten back-to-back reads land in order one cycle after each grant.
      applyStimulus(1, 0, 0, 0, 0, 0, '0, '0, '0, g);
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1, 1, 0, 0, 0, 0, AW'(32'h10 + i), '0, '0, g);
         checkOutput("read burst grant", 64'(g), 64'(2'b10));
         checkOutput("read burst cmd", {37'd0, data_out_ready_fifo, wr_fifo, address_fifo},
                     {37'd0, 1'b1, 1'b0, AW'(32'h10 + i)});
      end

      // Continuous contention: eight reads then one write, repeating.
      applyStimulus(1, 0, 0, 0, 0, 0, '0, '0, '0, g);
      for (int i = 0; i < 27; i++) begin
         applyStimulus(1, 1, 1, 0, 0, 0, AW'(i), 25'h1000 + AW'(i), 8'hC0 + 8'(i), g);
         checkOutput("burst pattern", 64'(g), (i % 9 == 8) ? 64'(2'b01) : 64'(2'b10));
         if (i % 9 == 8)
            checkOutput("burst write beat", {55'd0, wr_fifo, data_out_fifo}, {55'd0, 1'b1, 8'hC0 + 8'(i)});
      end

      // Back-pressure: the command stays put and nothing is granted until the FIFO frees.
      applyStimulus(1, 0, 0, 0, 0, 0, '0, '0, '0, g);
      applyStimulus(1, 1, 0, 0, 0, 0, 25'h40, '0, '0, g);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1, 1, 1, 1, 0, 0, 25'h41, 25'h99, 8'h55, g);
         checkOutput("stall grants", 64'(g), 64'd0);
         checkOutput("stall hold", {37'd0, data_out_ready_fifo, wr_fifo, address_fifo},
                     {37'd0, 1'b1, 1'b0, 25'h40});
      end
      applyStimulus(1, 1, 1, 0, 0, 0, 25'h41, 25'h99, 8'h55, g);
      checkOutput("stall release grant", 64'(g), 64'(2'b10));
      checkOutput("stall release cmd", {39'd0, address_fifo}, {39'd0, 25'h41});

      // Flip requested at cycle 3 (again at 5), applied at the frame boundary at cycle 20.
      applyStimulus(0, 0, 0, 0, 0, 0, '0, '0, '0, g);
      for (int i = 0; i < 26; i++) begin
         applyStimulus(1, 0, 0, 0, (i == 20), (i == 3 || i == 5), '0, '0, '0, g);
         checkOutput($sformatf("flip cycle %0d", i), {62'd0, frame_buffer_select, flip_done},
                     {62'd0, (i >= 20), (i == 20)});
      end

      // Reset while a write sits blocked behind a full FIFO.
      applyStimulus(1, 0, 1, 0, 0, 1, '0, 25'h1ABCDE, 8'hE7, g);
      applyStimulus(1, 0, 1, 1, 1, 0, '0, 25'h1ABCDE, 8'hE7, g);
      applyStimulus(0, 1, 1, 1, 0, 0, 25'h5, 25'h6, 8'h77, g);
      checkOutput("reset drop grants", 64'(g), 64'd0);
      checkOutput("reset drop outputs", outVec(), 64'd0);

      for (int i = 0; i < 400; i++) begin
         rr = ($urandom_range(3) != 0);
         rw = ($urandom_range(2) == 0);
         rf = ($urandom_range(3) == 0);
         rs = ($urandom_range(15) == 0);
         rp = ($urandom_range(9) == 0);
         rn = ($urandom_range(63) != 0);
         applyStimulus(rn, rr, rw, rf, rs, rp, AW'($urandom), AW'($urandom), 8'($urandom), g);
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/frame_ram_arbiter.md
FRAME_RAM_ARBITER -- requirements
Module: frame_ram_arbiter

Interface
REQ-001 Parameter: ADDRESS_WIDTH, 25, width of the frame RAM word address.
REQ-002 Parameter: RD_BURST_LIMIT, 8, maximum consecutive read grants allowed while a write is pending.
REQ-003 Port: clk  input  1  the single clock; all logic is on its rising edge.
REQ-004 Port: reset_n  input  1  reset, synchronous, active-low.
REQ-005 Port: rd_req  input  1  display refresh fetcher requests one read beat.
REQ-006 Port: rd_address  input  ADDRESS_WIDTH  read address; valid while rd_req=1.
REQ-007 Port: rd_grant  output  1  read beat accepted this cycle.
REQ-008 Port: wr_req  input  1  host frame writer requests one write beat.
REQ-009 Port: wr_address  input  ADDRESS_WIDTH  write address; valid while wr_req=1.
REQ-010 Port: wr_data  input  8  RGB332 pixel to write.
REQ-011 Port: wr_grant  output  1  write beat accepted this cycle.
REQ-012 Port: address_fifo  output  ADDRESS_WIDTH  registered address to the RAM command FIFO.
REQ-013 Port: wr_fifo  output  1  registered command type: 1 = write, 0 = read.
REQ-014 Port: data_out_fifo  output  8  registered write data; 0 on read beats.
REQ-015 Port: data_out_ready_fifo  output  1  command valid to the RAM FIFO.
REQ-016 Port: fifo_full  input  1  RAM FIFO cannot accept a command.
REQ-017 Port: frame_start  input  1  one-cycle pulse at the display frame boundary (line_select wrap 15 -> 0).
REQ-018 Port: flip_req  input  1  one-cycle host request to swap display/draw buffers.
REQ-019 Port: frame_buffer_select  output  1  buffer currently being displayed.
REQ-020 Port: flip_done  output  1  one-cycle pulse that acknowledges the applied swap.

Function
REQ-021 A command transfers when data_out_ready_fifo=1 and fifo_full=0.
REQ-022 The output slot is free when data_out_ready_fifo=0 or a transfer occurs in the same cycle.
REQ-023 Grants are combinational: at most one of rd_grant/wr_grant is high, and only when the slot is free and the matching req is high.
REQ-024 A granted beat loads address_fifo/wr_fifo/data_out_fifo and sets data_out_ready_fifo on the next edge (1-cycle latency); with no grant and a transfer, data_out_ready_fifo clears.
REQ-025 While fifo_full=1 and data_out_ready_fifo=1, all output registers are held stable and no grant is issued.
REQ-026 Arbitration state machine: ARB_IDLE (last grant none), ARB_RD (last grant read), ARB_WR (last grant write); each grant moves to the matching state, and a free slot with no request returns to ARB_IDLE.
REQ-027 Read has priority, except that a 4-bit-minimum saturating counter tracks consecutive read grants while wr_req=1; when it equals RD_BURST_LIMIT and both requests are high, the write is granted.
REQ-028 The counter clears on any write grant and on any cycle with wr_req=0.
REQ-029 Flip: flip_req sets flip_pending; flip_req while pending is ignored (no second swap).
REQ-030 On frame_start with flip_pending=1 (or flip_req=1 in the same cycle), toggle frame_buffer_select, clear flip_pending, and pulse flip_done on the next cycle.
REQ-031 frame_start with no flip pending leaves frame_buffer_select unchanged and gives no flip_done.
REQ-032 A swap never changes a command already in the output register.

Reset
REQ-033 When reset_n=0 at a clock edge, set data_out_ready_fifo, wr_fifo, address_fifo, data_out_fifo, frame_buffer_select, flip_done, flip_pending, and the burst counter to 0, and the state to ARB_IDLE.
REQ-034 Grants are 0 while reset_n=0; a beat in flight when reset is asserted is dropped.

Structure
REQ-035 The shared package led_matrix_pkg holds ADDRESS_WIDTH, the RGB332 pixel type, and the arbiter state enumeration.
REQ-036 Flip logic is the sub-module frame_flip_scheduler (inputs frame_start and flip_req; outputs frame_buffer_select and flip_done).

Verification
REQ-037 rd_req=1 for 10 cycles with rd_address 0x10..0x19 and fifo_full=0 -> 10 read commands in order, each 1 cycle after its rd_grant, wr_fifo=0.
REQ-038 rd_req=wr_req=1 held continuously, RD_BURST_LIMIT=8 -> grant pattern of 8 reads then 1 write, repeating; wr_fifo=1 with data_out_fifo=wr_data on write beats.
REQ-039 A command is pending with fifo_full=1 for 5 cycles -> outputs held, no grants; fifo_full drops -> transfer, then the next grant in the same cycle.
REQ-040 flip_req at cycle 3, frame_start at cycle 20 -> frame_buffer_select toggles after cycle 20 and flip_done pulses at cycle 21 only; a second flip_req at cycle 5 produces no extra toggle.
REQ-041 flip_req and frame_start in the same cycle -> immediate toggle plus flip_done; frame_start alone afterwards -> no change.
REQ-042 reset_n=0 for 1 cycle while a write is pending under fifo_full=1 -> all outputs 0 next cycle and the arbiter in ARB_IDLE.
